load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit of the RISC-V pipeline. It takes the ALU address and rs2 store data for a load or store, runs a req/ack transaction on the data-memory bus, and aligns and sign-extends load data. The result is the registered `rdata3` word consumed by the write-back select (`wb_sel = 2'b10`). It stalls the pipeline while a transaction is in flight and flags misaligned, illegal and timed-out accesses.

## Interface
- `TIMEOUT`, 16: ACCESS-state cycles without `bus_ack` before the access is abandoned (≥2).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_rd`  in  1  load in MEM stage.
- `mem_wr`  in  1  store in MEM stage.
- `funct3`  in  3  RV32I load/store width/sign code.
- `addr`  in  32  effective byte address (ALU `opr_res`).
- `wdata_in`  in  32  store data (rs2).
- `flush`  in  1  MEM-stage instruction is squashed.
- `bus_ack`  in  1  memory accepted/completed the request; `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  32  memory read word.
- `bus_req`  out  1  request, held until ack or timeout.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address (`addr[31:2], 2'b00`).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_wstrb`  out  4  byte strobes (0 for loads).
- `rdata3`  out  32  formatted load result to write-back.
- `lsu_stall`  out  1  hold IF/ID/EX/MEM registers.
- `lsu_done`  out  1  one-cycle completion pulse.
- `misalign_fault`  out  1  one-cycle pulse, misaligned address.
- `access_fault`  out  1  one-cycle pulse, illegal op or bus timeout.

## Operation
- FSM states: IDLE, ACCESS, DONE. All outputs are registered except `lsu_stall`.
- `lsu_stall` = (IDLE & (mem_rd | mem_wr) & !flush) | ACCESS. It is 0 in DONE, so the pipeline advances at the end of DONE.
- IDLE with a request and no `flush`:
  - Latch `addr`, `funct3`, `wdata_in` and direction.
  - Illegal request (`mem_rd & mem_wr`, or `funct3` ∈ {011, 110, 111}; loads also 011) → DONE with `access_fault`; no bus request.
  - Misaligned request (half with `addr[0]=1`, word with `addr[1:0]≠0`) → DONE with `misalign_fault`; no bus request.
  - Otherwise → ACCESS: `bus_req=1`, timeout counter cleared.
- ACCESS, `bus_ack=1`:
  - Drop `bus_req`.
  - Load: capture the formatted result into `rdata3`.
  - → DONE with `lsu_done`.
- ACCESS, no ack: counter increments. At count TIMEOUT-1: drop `bus_req`, set `rdata3=0`, → DONE with `access_fault`.
- DONE: pulse flags are high for exactly this cycle → IDLE.
- Load formatting, lane = `addr[1:0]`:
  - LB/LBU: byte at lane, sign/zero extended.
  - LH/LHU: half at `addr[1]`, sign/zero extended.
  - LW: whole word.
- Store lanes:
  - SB: strobe `4'b0001 << lane`, data `{4{wdata_in[7:0]}}`.
  - SH: strobe `4'b0011 << addr[1:0]`, data `{2{wdata_in[15:0]}}`.
  - SW: strobe `4'b1111`, data `wdata_in`.
- `rdata3` holds its value through stores, faults (except timeout) and idle cycles.
- `flush` is honoured only in IDLE. Once ACCESS is entered, the transaction completes or times out regardless of `flush`.
- Bus outputs are stable from ACCESS entry until ack or timeout. `bus_addr`/`bus_wdata`/`bus_wstrb` are don't-care while `bus_req=0`.

## Timing
- Reset (`rst=0`, asynchronous): state IDLE, counter 0, `rdata3=0`, all bus outputs and flags 0, `lsu_stall` follows the IDLE equation.
- Reset asserted mid-ACCESS drops `bus_req` immediately. No fault or done pulse is produced.
- Best-case aligned access: 3 cycles (IDLE detect, ACCESS with same-cycle ack, DONE). Pipeline stall is 2 cycles.
- Each additional wait cycle adds 1 cycle of stall.
- Timeout case: IDLE + TIMEOUT ACCESS cycles + DONE.
- Fault without bus request: 2 cycles (IDLE, DONE). Stall is 1 cycle.
- Back-to-back accesses: the next request is sampled in the cycle after DONE. There is no IDLE bubble beyond that.
- An ack arriving in the timeout cycle counts as success; success has priority over timeout.

## Test plan
- Reset mid-transaction: reset during ACCESS with `bus_req=1` → `bus_req` drops asynchronously; after release, state is IDLE and `rdata3=0`.
- LB at `addr=0x1003`, `bus_rdata=0x80FF_1234`, ack in the first ACCESS cycle → `bus_addr=0x1000`, `rdata3=0xFFFF_FF80`, `lsu_done` in cycle 3, stall for 2 cycles. The same access as LBU → `rdata3=0x0000_0080`.
- SH at `addr=0x2002`, `wdata_in=0xDEAD_BEEF`, ack after 3 wait cycles → `bus_we=1`, `bus_wstrb=4'b1100`, `bus_wdata=0xBEEF_BEEF`, stall for 5 cycles, `rdata3` unchanged.
- LW at `addr=0x0006` → `misalign_fault` pulse, no `bus_req`, stall 1 cycle. `mem_rd=mem_wr=1` → `access_fault` pulse, no `bus_req`.
- LW with `TIMEOUT=16` and ack never asserted → `bus_req` high for 16 cycles, then `access_fault` pulse and `rdata3=0`. A repeat with ack on the 16th cycle → success and `lsu_done`.
- `flush=1` with `mem_rd=1` in IDLE → no stall, no request. `flush` raised during ACCESS → the transaction still completes with `lsu_done`.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: runs one req/ack bus transaction per load or
// store, aligns and sign-extends load data into rdata3, and reports
// misaligned, illegal and timed-out accesses as one-cycle pulses.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  input  logic        flush,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] rdata3,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic        misalign_fault,
  output logic        access_fault
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    lane, lane_nx;
  logic [2:0]    fn, fn_nx;
  logic          bus_req_nx, bus_we_nx;
  logic [31:0]   bus_addr_nx, bus_wdata_nx, rdata3_nx;
  logic [3:0]    bus_wstrb_nx;
  logic          done_nx, misalign_nx, access_nx;

  logic          req, illegal, misaligned;
  logic [3:0]    st_strb;
  logic [31:0]   st_data;

  // Byte/half/word extraction of a load word; halves are aligned, so the same
  // lane shift serves both widths.
  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] ln,
                                      input logic [2:0] f);
    logic [31:0] sh;
    sh = w >> {ln, 3'b000};
    case (f[1:0])
      2'b00:   fmt = f[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   fmt = f[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: fmt = w;
    endcase
  endfunction

  assign req        = (mem_rd | mem_wr) & ~flush;
  assign illegal    = (mem_rd & mem_wr) | (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
  assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign lsu_stall  = ((state == IDLE) & req) | (state == ACCESS);

  // Store lane steering: strobes shifted to the byte lane, data replicated.
  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata_in;
    case (funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr[1:0];
        st_data = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << addr[1:0];
        st_data = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Next state and next values of every registered output; pulses default low.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lane_nx      = lane;
    fn_nx        = fn;
    bus_req_nx   = bus_req;
    bus_we_nx    = bus_we;
    bus_addr_nx  = bus_addr;
    bus_wdata_nx = bus_wdata;
    bus_wstrb_nx = bus_wstrb;
    rdata3_nx    = rdata3;
    done_nx      = 1'b0;
    misalign_nx  = 1'b0;
    access_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          lane_nx = addr[1:0];
          fn_nx   = funct3;
          if (illegal) begin
            access_nx = 1'b1;
            state_nx  = DONE;
          end else if (misaligned) begin
            misalign_nx = 1'b1;
            state_nx    = DONE;
          end else begin
            bus_req_nx   = 1'b1;
            bus_we_nx    = mem_wr;
            bus_addr_nx  = {addr[31:2], 2'b00};
            bus_wdata_nx = st_data;
            bus_wstrb_nx = mem_wr ? st_strb : 4'b0000;
            cnt_nx       = '0;
            state_nx     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus_ack) begin
          bus_req_nx = 1'b0;
          if (!bus_we) rdata3_nx = fmt(bus_rdata, lane, fn);
          done_nx  = 1'b1;
          state_nx = DONE;
        end else if (cnt == LAST) begin
          bus_req_nx = 1'b0;
          rdata3_nx  = '0;
          access_nx  = 1'b1;
          state_nx   = DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Registered datapath, bus outputs and pulse flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      lane           <= '0;
      fn             <= '0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_wstrb      <= '0;
      rdata3         <= '0;
      lsu_done       <= 1'b0;
      misalign_fault <= 1'b0;
      access_fault   <= 1'b0;
    end else begin
      cnt            <= cnt_nx;
      lane           <= lane_nx;
      fn             <= fn_nx;
      bus_req        <= bus_req_nx;
      bus_we         <= bus_we_nx;
      bus_addr       <= bus_addr_nx;
      bus_wdata      <= bus_wdata_nx;
      bus_wstrb      <= bus_wstrb_nx;
      rdata3         <= rdata3_nx;
      lsu_done       <= done_nx;
      misalign_fault <= misalign_nx;
      access_fault   <= access_nx;
    end
  end

endmodule
